// File: rtl/ray_vec_pkg.sv
// ray_vec_pkg: shared vector layout and output-buffer state encoding for the ray vector datapath
package ray_vec_pkg;
  localparam int COMP_W = 19;
  localparam int VEC_W = 57;
  localparam int X_LSB = 38;
  localparam int Y_LSB = 19;
  localparam int Z_LSB = 0;
  typedef logic [VEC_W-1:0] vec_t;
  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or above ptr with wrap-around, as one-hot and index
module rr_priority_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // scan from farthest to nearest offset so the nearest request wins
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    gnt = '0;
    gnt[idx] = |req;
  end
endmodule

// File: rtl/signed_vector_addition.sv
// signed_vector_addition: per-component 19-bit wrapping add, no carry between components
module signed_vector_addition
  import ray_vec_pkg::*;
(
  input  vec_t a,
  input  vec_t b,
  output vec_t sum
);
  assign sum = {a[X_LSB +: COMP_W] + b[X_LSB +: COMP_W],
                a[Y_LSB +: COMP_W] + b[Y_LSB +: COMP_W],
                a[Z_LSB +: COMP_W] + b[Z_LSB +: COMP_W]};
endmodule

// File: rtl/vec_add_arbiter.sv
// vec_add_arbiter: round-robin share of one vector adder with a registered result; VEC_ADD_ARB_OVF_EN adds overflow flags
module vec_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int VEC_W = 57
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VEC_W-1:0] req_a,
  input  logic [NUM_REQ*VEC_W-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [VEC_W-1:0]         res_vector,
  output logic [ID_W-1:0]          res_id,
  output logic [2:0]               res_ovf
);
  import ray_vec_pkg::*;
  buf_state_e state, state_n;
  logic [ID_W-1:0] rr_ptr, win, ptr_n;
  logic [NUM_REQ-1:0] gnt;
  logic can_accept, take;
  vec_t a_sel, b_sel, sum;
  rr_priority_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(win)
  );
  assign a_sel = req_a[int'(win)*VEC_W +: VEC_W];
  assign b_sel = req_b[int'(win)*VEC_W +: VEC_W];
  signed_vector_addition u_add (
    .a(a_sel),
    .b(b_sel),
    .sum(sum)
  );
  assign res_valid = state == BUF_FULL;
  // grant only while the result register is free or draining this cycle
  always_comb begin
    can_accept = !rst && (state == BUF_EMPTY || res_ready);
    take = can_accept && |req_valid;
    req_ready = can_accept ? gnt : '0;
    state_n = take ? BUF_FULL : res_ready ? BUF_EMPTY : state;
    ptr_n = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end
  // output-buffer state register
  always_ff @(posedge clk)
    state <= rst ? BUF_EMPTY : state_n;
  // load the winner's sum and advance the pointer past it on every transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vector <= '0;
      res_id <= '0;
      rr_ptr <= '0;
    end else if (take) begin
      res_vector <= sum;
      res_id <= win;
      rr_ptr <= ptr_n;
    end
  end
`ifdef VEC_ADD_ARB_OVF_EN
  logic [2:0] ovf_n;
  // overflow when operand signs agree and the sum sign disagrees
  always_comb begin
    ovf_n = '0;
    for (int k = 0; k < 3; k++)
      ovf_n[k] = (a_sel[k*COMP_W+COMP_W-1] == b_sel[k*COMP_W+COMP_W-1]) &&
                 (sum[k*COMP_W+COMP_W-1] != a_sel[k*COMP_W+COMP_W-1]);
  end
  // overflow flags travel with the result
  always_ff @(posedge clk) begin
    if (rst) res_ovf <= '0;
    else if (take) res_ovf <= ovf_n;
  end
`else
  assign res_ovf = '0;
`endif
endmodule

// File: tb/tb_vec_add_arbiter.sv
// tb_vec_add_arbiter: scoreboard bench for the round-robin vector adder arbiter
module tb_vec_add_arbiter;
  localparam int N = 4;
  localparam int W = 57;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic res_valid;
  logic res_ready = 0;
  logic [W-1:0] res_vector;
  logic [1:0] res_id;
  logic [2:0] res_ovf;
  always #5 clk = ~clk;
  vec_add_arbiter #(.NUM_REQ(N), .ID_W(2), .VEC_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_vector(res_vector),
    .res_id(res_id),
    .res_ovf(res_ovf)
  );
  typedef struct {
    logic [W-1:0] v;
    logic [1:0] id;
    logic [2:0] o;
  } exp_t;
  exp_t sb[$];
  int grants[$];
  int n_chk = 0;
  int n_fail = 0;
  bit m_full = 0;
  int m_ptr = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] vec(int x, int y, int z);
    return {19'(x), 19'(y), 19'(z)};
  endfunction
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, int id);
    exp_t e;
    e.id = 2'(id);
    e.o = '0;
    e.v = '0;
    for (int k = 0; k < 3; k++) begin
      int s;
      s = int'($signed(a[k*19 +: 19])) + int'($signed(b[k*19 +: 19]));
      e.v[k*19 +: 19] = 19'(s);
`ifdef VEC_ADD_ARB_OVF_EN
      e.o[k] = (s > 262143) || (s < -262144);
`endif
    end
    return e;
  endfunction
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int w;
    bit found;
    check("res_valid", res_valid, m_full);
    if (m_full && sb.size() > 0) begin
      check("res_vector", res_vector, sb[0].v);
      check("res_id", res_id, sb[0].id);
      check("res_ovf", res_ovf, sb[0].o);
    end
    found = 0;
    w = 0;
    for (int k = 0; k < N; k++)
      if (!found && req_valid[(m_ptr + k) % N]) begin
        w = (m_ptr + k) % N;
        found = 1;
      end
    exp_rdy = '0;
    if (!rst && (!m_full || res_ready) && found) exp_rdy[w] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (rst) begin
      m_full = 0;
      m_ptr = 0;
      sb.delete();
    end else begin
      if (m_full && res_ready && sb.size() > 0) void'(sb.pop_front());
      if (exp_rdy != '0) begin
        grants.push_back(w);
        sb.push_back(model(req_a[w*W +: W], req_b[w*W +: W], w));
        m_ptr = (w + 1) % N;
        m_full = 1;
      end else if (res_ready) m_full = 0;
    end
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask
  task automatic do_reset();
    rst = 1;
    step(2);
    rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
    int exp_sp[5] = '{1, 3, 1, 3, 1};
    logic [W-1:0] snap_v;
    logic [1:0] snap_id;
    req_valid = 4'b0001;
    step(2);
    check("rst_valid", res_valid, 0);
    check("rst_vector", res_vector, 0);
    check("rst_id", res_id, 0);
    check("rst_ovf", res_ovf, 0);
    check("rst_ready", req_ready, 0);
    req_valid = '0;
    rst = 0;
    step();
    res_ready = 1;
    set_req(2, vec(5, -3, 0), vec(1, 1, 1));
    step();
    req_valid = '0;
    check("single_valid", res_valid, 1);
    check("single_vector", res_vector, vec(6, -2, 1));
    check("single_id", res_id, 2);
    step();
    check("single_drain", res_valid, 0);
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++)
      set_req(i, W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}));
    step(6);
    res_ready = 0;
    snap_v = res_vector;
    snap_id = res_id;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_vector", res_vector, snap_v);
      check("bp_id", res_id, snap_id);
      check("bp_ready", req_ready, 0);
    end
    check("rr_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("rr_order", grants[i], exp_rr[i]);
    res_ready = 1;
    #1;
    check("bp_regrant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step(2);
    do_reset();
    set_req(0, vec(262143, 0, 0), vec(1, 0, 0));
    step();
    req_valid = '0;
    check("ovf_x_sum", res_vector[56:38], 19'h40000);
`ifdef VEC_ADD_ARB_OVF_EN
    check("ovf_x_flag", res_ovf, 3'b100);
`else
    check("ovf_x_flag", res_ovf, 3'b000);
`endif
    set_req(1, vec(0, 0, -262144), vec(0, 0, -1));
    step();
    req_valid = '0;
    check("ovf_z_sum", res_vector[18:0], 19'h3FFFF);
`ifdef VEC_ADD_ARB_OVF_EN
    check("ovf_z_flag", res_ovf, 3'b001);
`else
    check("ovf_z_flag", res_ovf, 3'b000);
`endif
    step();
    set_req(0, vec(1, 2, 3), vec(4, 5, 6));
    set_req(2, vec(-7, 8, -9), vec(10, -11, 12));
    step(3);
    check("mid_full", res_valid, 1);
    rst = 1;
    req_valid = 4'b1010;
    step();
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_ready", req_ready, 0);
    grants.delete();
    rst = 0;
    step(5);
    check("sp_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("sp_order", grants[i], exp_sp[i]);
    req_valid = '0;
    step(2);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_add_arbiter.md
# vec_add_arbiter

Round-robin arbiter and sequencer that shares one `signed_vector_addition` datapath between several ray-tracing requesters, such as the ray generator, the intersection stage and the shading stage. It accepts one operand pair per cycle from the winning requester and drives it through the combinational adder. It registers the 57-bit sum with the winner's ID and returns it over a valid/ready handshake. It sits between the per-stage request queues and the shared vector arithmetic unit.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default 2: requester ID width, equal to $clog2(NUM_REQ).
- `VEC_W`, default 57: packed vector width, three 19-bit two's-complement components.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  NUM_REQ*VEC_W  flattened operand A; requester i occupies bits [i*VEC_W +: VEC_W].
- `req_b`  in  NUM_REQ*VEC_W  flattened operand B, same packing.
- `res_valid`  out  1  result register holds a valid sum.
- `res_ready`  in  1  consumer accepts the result.
- `res_vector`  out  VEC_W  sum: x in [56:38], y in [37:19], z in [18:0].
- `res_id`  out  ID_W  index of the requester that produced the result.
- `res_ovf`  out  3  per-component signed overflow {x,y,z}; see Configuration.

## Operation
- Output-buffer FSM has two states, EMPTY and FULL.
  - EMPTY: res_valid=0. If any req_valid is high, grant and go to FULL.
  - FULL: res_valid=1. If res_ready is high and any req_valid is high, grant and stay FULL (back-to-back). If res_ready is high and no request is pending, go to EMPTY. If res_ready is low, hold all outputs stable and grant nothing.
- Grant condition is `can_accept = (state==EMPTY) | res_ready`.
- The winner is the first asserted req_valid searching upward from `rr_ptr` with wrap-around.
  - req_ready[winner] = can_accept; all other req_ready bits are 0.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - req_ready depends combinationally on req_valid and res_ready; it is never a register.
- On a transfer:
  - res_vector ← sum of req_a[winner] and req_b[winner].
  - res_id ← winner.
  - rr_ptr ← (winner+1) mod NUM_REQ.
- If no transfer occurs, rr_ptr holds.
- Arithmetic: per-component 19-bit two's-complement addition with wrap-around. There is no saturation and no carry between components; this is identical to `signed_vector_addition`.
- Requesters must hold req_a, req_b and req_valid stable until accepted. The block does not check this.

## Timing
- Latency is 1 cycle: a transfer at edge N makes res_valid high after edge N.
- Throughput is 1 result per cycle while res_ready stays high.
- Fairness: with all requesters continuously valid, each gets exactly one grant per NUM_REQ cycles. Worst-case wait is NUM_REQ-1 grants.
- Reset, sampled at the rising edge:
  - state=EMPTY, res_valid=0, res_vector=0, res_id=0, res_ovf=0, rr_ptr=0.
  - req_ready=0 while rst is high.
- Reset mid-operation discards any held result without a handshake. Requests presented in the reset cycle are not accepted.
- Simultaneous res_ready and new grant in FULL: the old result retires and the new result loads on the same edge, with no bubble.

## Configuration
- Macro: `VEC_ADD_ARB_OVF_EN`.
- When defined, `res_ovf[k]` is registered with the result. It is 1 when component k's operands share a sign and the sum's sign differs (x=bit 2, z=bit 0).
- When undefined, `res_ovf` is constant 3'b000 and the overflow logic is not synthesised. The port remains present in both builds.

## Structure
- Shared package `ray_vec_pkg`:
  - `COMP_W=19`, `VEC_W=57`.
  - Component bit offsets `X_LSB=38`, `Y_LSB=19`, `Z_LSB=0`.
  - Typedef `vec_t` (logic [56:0]).
  - FSM state enum `{BUF_EMPTY, BUF_FULL}`.
- Sub-modules:
  - `signed_vector_addition` is instantiated unchanged as the datapath.
  - `rr_priority_pick` is a new, natural sub-module. It takes the request vector and rr_ptr and outputs a one-hot grant plus the encoded index.

## Test plan
- Single request: requester 2 sends a=(5,-3,0), b=(1,1,1). Expect res_valid 1 cycle later, res_vector=(6,-2,1), res_id=2, req_ready[2] high for one cycle only.
- Round-robin: all 4 valid continuously and res_ready=1. Expect res_id sequence 0,1,2,3,0,1 with no bubbles.
- Backpressure: hold res_ready=0 for 5 cycles while FULL. Expect res_vector and res_id stable, all req_ready=0. Expect the next grant in the cycle res_ready rises.
- Overflow with macro: x: 262143+1. Expect res_vector[56:38]=19'h40000 (-262144) and res_ovf=3'b100. Without the macro, expect the same sum and res_ovf=0.
- Reset mid-stream: assert rst while FULL with requests pending. Expect res_valid=0 and rr_ptr=0 after the edge, and the first post-reset grant to go to the lowest valid index.
- Sparse requests: requesters 1 and 3 valid, rr_ptr=2. Expect grant order 3,1,3,1.
